hamming_uart_receiver: RTL and testbench
========================================

# hamming_uart_receiver

Receive-side counterpart of the transmit unit. It oversamples the incoming serial line on the fast system clock and reassembles 8-bit UART frames. Each frame is decoded as an extended Hamming (8,4) codeword, and the block delivers the corrected 4-bit nibble with error flags. It sits at the end of the link and feeds the display/status logic.

## Interface
- `OVERSAMPLE`, default 16: system clocks per serial bit; even, ≥ 4. Matches the transmitter's ÷16 bit clock.
- `clk` input 1: system clock, the same clock that drives the transmitter's divider input.
- `rstn` input 1: reset. Asynchronous, active-low.
- `serial_in` input 1: UART line, idle high, asynchronous to `clk`.
- `data_out` output 4: decoded (corrected when possible) nibble.
- `code_out` output 8: raw received codeword.
- `syndrome` output 3: Hamming syndrome {s4,s2,s1}.
- `data_valid` output 1: one-cycle pulse; the outputs above are updated in the same cycle.
- `err_corrected` output 1: single-bit error corrected; valid with `data_valid`.
- `err_double` output 1: uncorrectable double error; valid with `data_valid`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- Frame format: one start bit (0), then 8 data bits LSB first, then one stop bit (1). There is no parity bit.
- Input sync: 2-FF synchronizer on `serial_in`, both flops reset to 1. All logic uses the synchronized value `rx_s`.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`, `WAIT_HIGH`.
  - `IDLE`: a 1→0 transition on `rx_s` goes to `START` and clears the tick counter. A line that is low out of reset is not a start; the FSM waits for high first.
  - `START`: after `OVERSAMPLE/2` cycles, sample `rx_s`. If 1, it is a glitch: return to `IDLE` with no output. If 0, go to `DATA` with bit index 0.
  - `DATA`: sample every `OVERSAMPLE` cycles, at mid-bit. Shift the sample into bit[index]. After index 7, go to `STOP`.
  - `STOP`: sample at mid-bit after `OVERSAMPLE` cycles.
    - If 1: latch the codeword into the decoder, then go to `IDLE`.
    - If 0: pulse `frame_err`, discard the byte, go to `WAIT_HIGH`.
  - `WAIT_HIGH`: stay until `rx_s` = 1, then go to `IDLE`.
- Codeword layout: byte bit i = c_i.
  - c1 = p1, c2 = p2, c3 = d0, c4 = p4, c5 = d1, c6 = d2, c7 = d3.
  - c0 = even overall parity of c1..c7.
- Syndrome: s1 = c1^c3^c5^c7, s2 = c2^c3^c6^c7, s4 = c4^c5^c6^c7. P = XOR of all 8 bits.
- Decode:
  - s = 0, P = 0: clean.
  - P = 1: single error. Flip c[s] (s = 0 means c0 was hit) and set `err_corrected`.
  - s ≠ 0, P = 0: double error. Set `err_double`; `data_out` carries the uncorrected d bits.
- No backpressure. Outputs hold until the next `data_valid`. Error flags are qualified by `data_valid` only.

## Timing
- Let e be the first cycle `rx_s` is low.
  - Start sample: e + `OVERSAMPLE/2`.
  - Data bit k sample: e + `OVERSAMPLE/2` + `OVERSAMPLE`·(k+1).
  - Stop sample: e + `OVERSAMPLE/2` + 9·`OVERSAMPLE` (e+152 at the default).
- `data_valid` and the decoded outputs are registered one cycle after the stop sample.
- `frame_err` is asserted in the cycle after the stop sample.
- The serial edge reaches `rx_s` 2 cycles after it appears on `serial_in`.
- A new start edge is accepted from the cycle after the FSM re-enters `IDLE`. Back-to-back frames with a single stop bit are supported.
- Reset values: every output is 0, the FSM is in `IDLE`, and the shift register and counters are 0.
- Reset mid-frame: the partial frame is abandoned and no pulse is generated.

## Configuration
- `HAMMING_DED_EN` defined: full SEC-DED as described above.
- `HAMMING_DED_EN` undefined:
  - Plain Hamming(7,4). c0 is ignored and P is not used.
  - Any s ≠ 0 flips c[s] and sets `err_corrected`.
  - `err_double` is tied to 0.

## Structure
- Package `uart_rx_pkg` holds:
  - the FSM state enum;
  - the `OVERSAMPLE` default;
  - codeword position constants (P1, P2, D0, P4, D1, D2, D3, P0);
  - a pure function computing the syndrome.
- Sub-module `hamming_secded_decoder` takes the codeword and a load strobe and produces the registered nibble, syndrome and flags. It is clocked by `clk`/`rstn`.
- The UART FSM, synchronizer and counters live in the top level.

## Test plan
- Clean frame: send 8'hA5 (data 4'hA) → `data_out` = 4'hA, `syndrome` = 0, no flags, `data_valid` at e+153.
- Single-bit error: send 8'h85 (c5 flipped) → `data_out` = 4'hA, `syndrome` = 3'd5, `err_corrected` = 1.
- Parity-bit error: send 8'hA4 (c0 flipped) → `data_out` = 4'hA, `syndrome` = 0, `err_corrected` = 1.
- Double error: send 8'hC5.
  - With `HAMMING_DED_EN`: `err_double` = 1, `data_out` = 4'hC, `syndrome` = 3'd3.
  - Without it: `data_out` = 4'hD, `err_corrected` = 1.
- Framing and noise cases:
  - Stop bit held low, then line high: `frame_err` pulses once, no `data_valid`.
  - A 4-cycle low glitch on an idle line: no output.
- Reset during `DATA` bit 4, then a clean 8'h00 frame: no output for the aborted frame, then `data_out` = 0 with no flags.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the Hamming-coded UART receiver:
//     - rx_state_e           : receiver FSM states
//     - OVERSAMPLE_DEFAULT   : system clocks per serial bit
//     - P0..D3               : bit positions of each field inside the codeword
//     - calc_syndrome()      : {s4,s2,s1} of an 8-bit codeword
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Codeword layout: byte bit i carries c_i.
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int D0 = 3;
    localparam int P4 = 4;
    localparam int D1 = 5;
    localparam int D2 = 6;
    localparam int D3 = 7;

    // Returns {s4, s2, s1}; a nonzero value names the position of a single error.
    function automatic logic [2:0] calc_syndrome(input logic [7:0] c);
        logic s1;
        logic s2;
        logic s4;
        s1 = c[P1] ^ c[D0] ^ c[D1] ^ c[D3];
        s2 = c[P2] ^ c[D0] ^ c[D2] ^ c[D3];
        s4 = c[P4] ^ c[D1] ^ c[D2] ^ c[D3];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming_secded_decoder.sv
// ---------------------------------------------------------------------------
// hamming_secded_decoder
//   Decodes one 8-bit extended Hamming codeword per load strobe and registers
//   the result. Outputs hold until the next load.
//
//   Build option: define HAMMING_DED_EN for SEC-DED (overall parity c0 used);
//   without it the block is plain Hamming(7,4) and err_double is always 0.
//
//   Ports
//     clk, rstn      : clock, asynchronous active-low reset
//     load           : capture and decode code_in this cycle
//     code_in[7:0]   : received codeword
//     data_out[3:0]  : decoded nibble {d3,d2,d1,d0}
//     code_out[7:0]  : raw codeword as received
//     syndrome[2:0]  : {s4,s2,s1}
//     data_valid     : one-cycle pulse, the cycle after load
//     err_corrected  : a single error was corrected
//     err_double     : uncorrectable double error detected
// ---------------------------------------------------------------------------
module hamming_secded_decoder
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] code_in,
    output logic [3:0] data_out,
    output logic [7:0] code_out,
    output logic [2:0] syndrome,
    output logic       data_valid,
    output logic       err_corrected,
    output logic       err_double
);

    logic [2:0] syn;
    logic [7:0] fixed;
    logic       corr;
    logic       dbl;

    logic [3:0] data_q;
    logic [7:0] code_q;
    logic [2:0] syn_q;
    logic       valid_q;
    logic       corr_q;
    logic       dbl_q;

    always_comb begin
        syn   = calc_syndrome(code_in);
        fixed = code_in;
        corr  = 1'b0;
        dbl   = 1'b0;
`ifdef HAMMING_DED_EN
        // Odd overall parity means exactly one flip; syndrome 0 points at c0.
        if (^code_in) begin
            fixed[syn] = ~fixed[syn];
            corr       = 1'b1;
        end else if (syn != 3'd0) begin
            dbl = 1'b1;
        end
`else
        if (syn != 3'd0) begin
            fixed[syn] = ~fixed[syn];
            corr       = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            code_q  <= '0;
            syn_q   <= '0;
            valid_q <= 1'b0;
            corr_q  <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            valid_q <= load;
            if (load) begin
                data_q <= {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
                code_q <= code_in;
                syn_q  <= syn;
                corr_q <= corr;
                dbl_q  <= dbl;
            end
        end
    end

    assign data_out      = data_q;
    assign code_out      = code_q;
    assign syndrome      = syn_q;
    assign data_valid    = valid_q;
    assign err_corrected = corr_q;
    assign err_double    = dbl_q;

endmodule

// File: rtl/hamming_uart_receiver.sv
// ---------------------------------------------------------------------------
// hamming_uart_receiver
//   Oversampling UART receiver (1 start, 8 data LSB first, 1 stop, no parity)
//   feeding an extended Hamming(8,4) decoder.
//
//   Build option: HAMMING_DED_EN selects SEC-DED decoding (see decoder).
//
//   Ports
//     clk, rstn      : system clock, asynchronous active-low reset
//     serial_in      : UART line, idle high, asynchronous to clk
//     data_out[3:0]  : decoded nibble
//     code_out[7:0]  : raw received codeword
//     syndrome[2:0]  : {s4,s2,s1}
//     data_valid     : one-cycle pulse when the outputs above update
//     err_corrected  : single error corrected (qualified by data_valid)
//     err_double     : double error detected (qualified by data_valid)
//     frame_err      : one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module hamming_uart_receiver
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       serial_in,
    output logic [3:0] data_out,
    output logic [7:0] code_out,
    output logic [2:0] syndrome,
    output logic       data_valid,
    output logic       err_corrected,
    output logic       err_double,
    output logic       frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            rx_s;
    logic [1:0]      fill_q;
    logic            rx_prev_q;

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ferr_q, ferr_d;
    logic            load;

    // Two-flop synchronizer, idle-high reset values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;

    // rx_s only reflects the real line once the synchronizer has filled.
    // Masking the history until then keeps a line that is low out of reset
    // from looking like a 1->0 start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_q    <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            fill_q    <= {fill_q[0], 1'b1};
            rx_prev_q <= rx_s & fill_q[1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Mid-point of the start bit; a high line here is a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        load    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    hamming_secded_decoder u_decoder (
        .clk           (clk),
        .rstn          (rstn),
        .load          (load),
        .code_in       (shift_q),
        .data_out      (data_out),
        .code_out      (code_out),
        .syndrome      (syndrome),
        .data_valid    (data_valid),
        .err_corrected (err_corrected),
        .err_double    (err_double)
    );

    assign frame_err = ferr_q;

endmodule

// File: tb/tb_hamming_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_hamming_uart_receiver
//   Directed frames against a behavioural decoder model. The model derives the
//   syndrome as the XOR of the positions of all set bits c1..c7 and predicts
//   the exact cycle of every data_valid / frame_err pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hamming_uart_receiver;

    localparam int OS = 16;

    logic       clk;
    logic       rstn;
    logic       serial_in;
    logic [3:0] data_out;
    logic [7:0] code_out;
    logic [2:0] syndrome;
    logic       data_valid;
    logic       err_corrected;
    logic       err_double;
    logic       frame_err;

    hamming_uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .code_out      (code_out),
        .syndrome      (syndrome),
        .data_valid    (data_valid),
        .err_corrected (err_corrected),
        .err_double    (err_double),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         ferr;
        logic [3:0] d;
        logic [7:0] code;
        logic [2:0] syn;
        bit         corr;
        bit         dbl;
    } exp_t;

    exp_t expq[$];
    exp_t ce;
    int   total = 0;
    int   bad   = 0;
    bit   checking = 0;
`ifdef HAMMING_DED_EN
    localparam bit DED = 1'b1;
`else
    localparam bit DED = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] c);
        exp_t       r;
        int         s;
        bit         p;
        logic [7:0] f;
        s = 0;
        p = 1'b0;
        f = c;
        for (int i = 0; i < 8; i++) begin
            p ^= c[i];
            if (i > 0 && c[i]) s ^= i;
        end
        r.cyc  = 0;
        r.ferr = 1'b0;
        r.code = c;
        r.syn  = 3'(s);
        r.corr = 1'b0;
        r.dbl  = 1'b0;
        if (DED) begin
            if (p) begin
                f[s]   = ~f[s];
                r.corr = 1'b1;
            end else if (s != 0) begin
                r.dbl = 1'b1;
            end
        end else if (s != 0) begin
            f[s]   = ~f[s];
            r.corr = 1'b1;
        end
        r.d = {f[7], f[6], f[5], f[3]};
        return r;
    endfunction

    // Every-cycle compare against the expected pulse schedule.
    always @(negedge clk) begin
        if (checking && rstn) begin
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                check("missed_pulse", 32'(expq[0].cyc), 32'(cyc));
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                ce = expq.pop_front();
                check("data_valid", 32'(data_valid), 32'(!ce.ferr));
                check("frame_err",  32'(frame_err),  32'(ce.ferr));
                if (!ce.ferr) begin
                    check("data_out",      32'(data_out),      32'(ce.d));
                    check("code_out",      32'(code_out),      32'(ce.code));
                    check("syndrome",      32'(syndrome),      32'(ce.syn));
                    check("err_corrected", 32'(err_corrected), 32'(ce.corr));
                    check("err_double",    32'(err_double),    32'(ce.dbl));
                end
                $display("cycle %0d: %s code=%02h data=%h syn=%0d corr=%0b dbl=%0b",
                         cyc, ce.ferr ? "frame_err" : "data_valid",
                         code_out, data_out, syndrome, err_corrected, err_double);
            end else begin
                check("no_pulse", 32'({data_valid, frame_err}), 32'(0));
            end
        end
    end

    // Called just after a posedge; returns just after a posedge.
    task automatic send(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        #1;
        e      = model(b);
        e.cyc  = cyc + 155;   // 2 sync + 152 to stop sample + 1 register
        e.ferr = !stop_ok;
        expq.push_back(e);
        serial_in = 1'b0;
        repeat (OS) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 serial_in = b[k];
            repeat (OS) @(posedge clk);
        end
        #1 serial_in = stop_ok;
        repeat (OS) @(posedge clk);
    endtask

    task automatic check_outputs(input string name, input logic [3:0] d, input logic [7:0] c,
                                 input logic [2:0] s, input bit corr, input bit dbl);
        check({name, "_data"}, 32'(data_out),      32'(d));
        check({name, "_code"}, 32'(code_out),      32'(c));
        check({name, "_syn"},  32'(syndrome),      32'(s));
        check({name, "_corr"}, 32'(err_corrected), 32'(corr));
        check({name, "_dbl"},  32'(err_double),    32'(dbl));
    endtask

    initial begin
        exp_t m;
        rstn      = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 4'h0, 8'h00, 3'd0, 1'b0, 1'b0);
        check("reset_pulses", 32'({data_valid, frame_err}), 32'(0));
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (10) @(posedge clk);
        checking = 1'b1;

        // Pin the model itself with hand-computed decodes.
        m = model(8'hA5);
        check("model_A5", 32'({m.d, m.syn, m.corr, m.dbl}), 32'({4'hA, 3'd0, 1'b0, 1'b0}));
        m = model(8'h85);
        check("model_85", 32'({m.d, m.syn, m.corr, m.dbl}), 32'({4'hA, 3'd5, 1'b1, 1'b0}));
        m = model(8'hC5);
        check("model_C5", 32'({m.d, m.syn, m.corr, m.dbl}),
              DED ? 32'({4'hC, 3'd3, 1'b0, 1'b1}) : 32'({4'hD, 3'd3, 1'b1, 1'b0}));

        // Clean frame.
        send(8'hA5, 1'b1);
        repeat (20) @(posedge clk);
        check_outputs("clean", 4'hA, 8'hA5, 3'd0, 1'b0, 1'b0);

        // Single data-bit error at c5.
        send(8'h85, 1'b1);
        repeat (20) @(posedge clk);
        check_outputs("single", 4'hA, 8'h85, 3'd5, 1'b1, 1'b0);

        // Overall parity bit flipped.
        send(8'hA4, 1'b1);
        repeat (20) @(posedge clk);
        check_outputs("parity", 4'hA, 8'hA4, 3'd0, DED, 1'b0);

        // Double error.
        send(8'hC5, 1'b1);
        repeat (20) @(posedge clk);
        if (DED) check_outputs("double", 4'hC, 8'hC5, 3'd3, 1'b0, 1'b1);
        else     check_outputs("double", 4'hD, 8'hC5, 3'd3, 1'b1, 1'b0);

        // Back-to-back frames, single stop bit.
        send(8'h5A, 1'b1);
        send(8'hFF, 1'b1);
        repeat (20) @(posedge clk);
        check_outputs("b2b", 4'hF, 8'hFF, 3'd0, 1'b0, 1'b0);

        // Stop bit held low, then line returns high.
        send(8'h33, 1'b0);
        repeat (40) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (30) @(posedge clk);
        check_outputs("held", 4'hF, 8'hFF, 3'd0, 1'b0, 1'b0);

        // 4-cycle glitch on idle line.
        #1 serial_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (40) @(posedge clk);

        // Reset during DATA bit 4 of an all-zero frame.
        #1 serial_in = 1'b0;
        repeat (80) @(posedge clk);
        #1 rstn = 1'b0;
        serial_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_outputs("midreset", 4'h0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (20) @(posedge clk);
        send(8'h00, 1'b1);
        repeat (20) @(posedge clk);
        check_outputs("zero", 4'h0, 8'h00, 3'd0, 1'b0, 1'b0);

        check("pending_expectations", 32'(expq.size()), 32'(0));
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
